// File: rtl/bank_queue_pkg.sv
// Shared defaults, widths and FSM state type for the bank queue controller.
package bank_queue_pkg;

   localparam int DEPTH_DEF       = 7;
   localparam int SERVICE_SEC_DEF = 3;
   localparam int PCOUNT_W        = 3;
   localparam int WTIME_W         = 8;
   localparam int ELAPSED_W       = 6;

   typedef enum logic {
      IDLE    = 1'b0,
      SERVING = 1'b1
   } state_t;

endpackage

// File: rtl/bank_queue_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector giving a one-cycle pulse.
module sync_edge (
   input  logic FPGA_clk,
   input  logic reset_n,
   input  logic i_async,
   output logic o_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge FPGA_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_pulse = r_sync & ~r_prev;

endmodule

// File: rtl/bank_queue_ctrl.sv
// Bank queue controller: counts waiting customers and estimates the wait for a new arrival.
module bank_queue_ctrl
   import bank_queue_pkg::*;
#(
   parameter int DEPTH       = DEPTH_DEF,
   parameter int SERVICE_SEC = SERVICE_SEC_DEF
) (
   input  logic                FPGA_clk,
   input  logic                reset_n,
   input  logic                OneHzClk,
   input  logic                pin,
   input  logic                pout,
   output logic [PCOUNT_W-1:0] pcount,
   output logic [WTIME_W-1:0]  wtime,
   output logic                empty,
   output logic                full
);

   localparam logic [PCOUNT_W-1:0]  DEPTH_V    = PCOUNT_W'(DEPTH);
   localparam logic [ELAPSED_W-1:0] ELAPSED_MX = ELAPSED_W'(SERVICE_SEC - 1);
   localparam logic [WTIME_W-1:0]   SVC_V      = WTIME_W'(SERVICE_SEC);

   logic w_secTick;
   logic w_arrive;
   logic w_depart;

   state_t                r_state;
   logic [PCOUNT_W-1:0]   r_pcount;
   logic [ELAPSED_W-1:0]  r_elapsed;
   logic                  w_empty;
   logic                  w_full;

   sync_edge u_sec (
      .FPGA_clk (FPGA_clk),
      .reset_n  (reset_n),
      .i_async  (OneHzClk),
      .o_pulse  (w_secTick)
   );

   sync_edge u_pin (
      .FPGA_clk (FPGA_clk),
      .reset_n  (reset_n),
      .i_async  (pin),
      .o_pulse  (w_arrive)
   );

   sync_edge u_pout (
      .FPGA_clk (FPGA_clk),
      .reset_n  (reset_n),
      .i_async  (pout),
      .o_pulse  (w_depart)
   );

   assign w_empty = (r_pcount == '0);
   assign w_full  = (r_pcount == DEPTH_V);

   // A departure restarts the service timer for the next customer and overrides any tick.
   always_ff @(posedge FPGA_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_pcount  <= '0;
         r_elapsed <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_elapsed <= '0;
               if (w_arrive) begin
                  r_pcount <= PCOUNT_W'(1);
                  r_state  <= SERVING;
               end
            end
            SERVING: begin
               if (w_depart) begin
                  r_elapsed <= '0;
                  if (!w_arrive) begin
                     r_pcount <= r_pcount - PCOUNT_W'(1);
                     if (r_pcount == PCOUNT_W'(1))
                        r_state <= IDLE;
                  end
               end else begin
                  if (w_arrive && !w_full)
                     r_pcount <= r_pcount + PCOUNT_W'(1);
                  if (w_secTick && (r_elapsed < ELAPSED_MX))
                     r_elapsed <= r_elapsed + ELAPSED_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign pcount = r_pcount;
   assign empty  = w_empty;
   assign full   = w_full;
   assign wtime  = (r_state == SERVING)
                 ? (WTIME_W'(r_pcount) * SVC_V) - WTIME_W'(r_elapsed)
                 : '0;

endmodule

// File: tb/tb_bank_queue_ctrl.sv
// Directed self-checking bench for bank_queue_ctrl with DEPTH=7, SERVICE_SEC=3.
module tb_bank_queue_ctrl;

   logic       FPGA_clk;
   logic       reset_n;
   logic       OneHzClk;
   logic       pin;
   logic       pout;
   logic [2:0] pcount;
   logic [7:0] wtime;
   logic       empty;
   logic       full;

   int checkCount;
   int passCount;

   bank_queue_ctrl #(.DEPTH(7), .SERVICE_SEC(3)) dut (
      .FPGA_clk (FPGA_clk),
      .reset_n  (reset_n),
      .OneHzClk (OneHzClk),
      .pin      (pin),
      .pout     (pout),
      .pcount   (pcount),
      .wtime    (wtime),
      .empty    (empty),
      .full     (full)
   );

   initial FPGA_clk = 1'b0;
   always #5 FPGA_clk = ~FPGA_clk;

   task automatic waitNeg(input int n);
      for (int i = 0; i < n; i++) @(negedge FPGA_clk);
   endtask

   // Drive the chosen inputs high for four cycles, then low long enough to settle.
   task automatic applyStimulus(input logic doIn, input logic doOut, input logic doTick);
      @(negedge FPGA_clk);
      pin      = doIn;
      pout     = doOut;
      OneHzClk = doTick;
      waitNeg(4);
      pin      = 1'b0;
      pout     = 1'b0;
      OneHzClk = 1'b0;
      waitNeg(3);
   endtask

   task automatic checkOutput(input string tag, input logic [2:0] expPc, input logic [7:0] expWt);
      logic expEmpty;
      logic expFull;
      expEmpty = (expPc == 3'd0);
      expFull  = (expPc == 3'd7);
      checkCount++;
      assert (pcount === expPc) passCount++;
      else $error("[TB] FAIL %s.pcount observed=%0d expected=%0d", tag, pcount, expPc);
      checkCount++;
      assert (wtime === expWt) passCount++;
      else $error("[TB] FAIL %s.wtime observed=%0d expected=%0d", tag, wtime, expWt);
      checkCount++;
      assert (empty === expEmpty) passCount++;
      else $error("[TB] FAIL %s.empty observed=%0b expected=%0b", tag, empty, expEmpty);
      checkCount++;
      assert (full === expFull) passCount++;
      else $error("[TB] FAIL %s.full observed=%0b expected=%0b", tag, full, expFull);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset_n    = 1'b0;
      OneHzClk   = 1'b0;
      pin        = 1'b0;
      pout       = 1'b0;

      waitNeg(3);
      checkOutput("inReset", 3'd0, 8'd0);
      reset_n = 1'b1;
      waitNeg(3);
      checkOutput("afterReset", 3'd0, 8'd0);

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("threeArrive", 3'd3, 8'd9);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("tick1", 3'd3, 8'd8);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("tick2", 3'd3, 8'd7);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("tickSat", 3'd3, 8'd7);

      // Pout rises before edge k; pcount must still be old after k+1 and new after k+2.
      @(negedge FPGA_clk);
      pout = 1'b1;
      waitNeg(2);
      checkOutput("departLatencyK1", 3'd3, 8'd7);
      waitNeg(1);
      checkOutput("departLatencyK2", 3'd2, 8'd6);
      waitNeg(2);
      pout = 1'b0;
      waitNeg(3);
      checkOutput("departHeld", 3'd2, 8'd6);

      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("depart2", 3'd1, 8'd3);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("depart3", 3'd0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("departEmpty", 3'd0, 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("tickIdle", 3'd0, 8'd0);

      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("sevenArrive", 3'd7, 8'd21);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("arriveFull", 3'd7, 8'd21);

      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("drainToTwo", 3'd2, 8'd6);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("twoElapsed1", 3'd2, 8'd5);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("arriveDepart", 3'd2, 8'd6);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("twoElapsed1b", 3'd2, 8'd5);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("arriveDepartTick", 3'd2, 8'd6);

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("drainAll", 3'd0, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("arriveDepartEmpty", 3'd1, 8'd3);

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("fourElapsed1", 3'd4, 8'd11);

      // Reset lands between clock edges; outputs must clear without waiting for a clock.
      @(posedge FPGA_clk);
      #2;
      reset_n = 1'b0;
      pin     = 1'b1;
      #1;
      checkOutput("asyncReset", 3'd0, 8'd0);
      waitNeg(3);
      checkOutput("resetHoldPin", 3'd0, 8'd0);
      reset_n = 1'b1;
      waitNeg(6);
      checkOutput("pinAcrossRelease", 3'd1, 8'd3);
      pin = 1'b0;
      waitNeg(4);
      checkOutput("pinReleasedLow", 3'd1, 8'd3);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
